// File: rtl/uv_arb_rr.sv
// uv_arb_rr: registered N-way arbiter with fixed-priority and round-robin
// modes, plus a grant lock that the holder can keep for at most MAX_HOLD
// consecutive cycles before it is forced to yield.
module uv_arb_rr #(
  parameter int WIDTH    = 4,
  parameter int MAX_HOLD = 16,
  localparam int IDX_W   = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH),
  localparam int CNT_W   = ($clog2(MAX_HOLD + 1) < 1) ? 1 : $clog2(MAX_HOLD + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [WIDTH-1:0] req,
  input  logic [WIDTH-1:0] lock,
  output logic [WIDTH-1:0] grant,
  output logic             grant_vld,
  output logic [IDX_W-1:0] grant_idx
);

  // Last count value of a hold; only meaningful when the limit is enabled.
  localparam int HOLD_LAST = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;

  logic [WIDTH-1:0] grant_reg;
  logic             grant_vld_reg;
  logic [IDX_W-1:0] grant_idx_reg;
  logic [WIDTH-1:0] ptr_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic             hold;
  logic             forced;
  logic [WIDTH-1:0] req_drop;
  logic [WIDTH-1:0] req_eff;
  logic [WIDTH-1:0] req_hi;
  logic [WIDTH-1:0] cand;
  logic [WIDTH-1:0] win_oh;
  logic [IDX_W-1:0] win_idx;
  logic [WIDTH-1:0] ptr_next;

  // Hold / forced-release decision and the effective request vector.
  always_comb begin
    hold     = grant_vld_reg & req[grant_idx_reg] & lock[grant_idx_reg];
    forced   = hold && (MAX_HOLD != 0) && (cnt_reg == CNT_W'(HOLD_LAST));
    req_drop = req & ~grant_reg;
    req_eff  = req;
    // A forced holder yields only if somebody else is waiting; otherwise it
    // simply re-wins and its hold counter restarts.
    if (forced && (req_drop != '0)) begin
      req_eff = req_drop;
    end
  end

  // Winner selection: in round-robin mode prefer requests at or above the
  // pointer, falling back to the lowest set bit (which is the wrap-around).
  always_comb begin
    req_hi = req_eff & ~(ptr_reg - WIDTH'(1));
    cand   = req_eff;
    if (mode && (req_hi != '0)) begin
      cand = req_hi;
    end
    // Isolate the lowest set bit of the candidate set.
    win_oh  = cand & (~cand + WIDTH'(1));
    win_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (cand[i]) begin
        win_idx = IDX_W'(i);
      end
    end
    // Pointer moves to the channel just after the winner, wrapping.
    ptr_next = {win_oh[WIDTH-2:0], win_oh[WIDTH-1]};
  end

  // State register: grant, pointer and hold counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_reg     <= '0;
      grant_vld_reg <= 1'b0;
      grant_idx_reg <= '0;
      ptr_reg       <= WIDTH'(1);
      cnt_reg       <= '0;
    end else if (hold && !forced) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end else begin
      cnt_reg       <= '0;
      grant_reg     <= win_oh;
      grant_vld_reg <= (req_eff != '0);
      grant_idx_reg <= win_idx;
      if (mode && (req_eff != '0)) begin
        ptr_reg <= ptr_next;
      end
    end
  end

  assign grant     = grant_reg;
  assign grant_vld = grant_vld_reg;
  assign grant_idx = grant_idx_reg;

endmodule

// File: tb/tb_uv_arb_rr.sv
// tb_uv_arb_rr: directed vectors with hand-computed grants; a scoreboard
// queue decouples stimulus from the monitor that checks each cycle.
module tb_uv_arb_rr;

  localparam int W  = 4;
  localparam int MH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         mode = 1'b0;
  logic [W-1:0] req = '0;
  logic [W-1:0] lock = '0;
  logic [W-1:0] grant;
  logic         grant_vld;
  logic [1:0]   grant_idx;

  uv_arb_rr #(.WIDTH(W), .MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .req       (req),
    .lock      (lock),
    .grant     (grant),
    .grant_vld (grant_vld),
    .grant_idx (grant_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] grant;
    string        tag;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic logic [1:0] idx_of(input logic [W-1:0] g);
    logic [1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) begin
      if (g[i]) r = 2'(i);
    end
    return r;
  endfunction

  // Apply inputs away from the rising edge and queue the grant expected
  // after the next rising edge.
  task automatic step(input logic r, input logic m, input logic [W-1:0] rq,
                      input logic [W-1:0] lk, input logic [W-1:0] eg,
                      input string tag);
    exp_t e;
    @(negedge clk);
    rst  = r;
    mode = m;
    req  = rq;
    lock = lk;
    e.grant = eg;
    e.tag   = tag;
    sb_q.push_back(e);
  endtask

  // Monitor: check registered outputs just after each rising edge.
  initial begin
    exp_t       e;
    logic       ev;
    logic [1:0] ei;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e  = sb_q.pop_front();
        ev = |e.grant;
        ei = idx_of(e.grant);
        vectors++;
        if ((grant !== e.grant) || (grant_vld !== ev) || (grant_idx !== ei)) begin
          miscompares++;
          $display("FAIL %s vec %0d: got grant=%b vld=%b idx=%0d, want grant=%b vld=%b idx=%0d",
                   e.tag, vectors, grant, grant_vld, grant_idx, e.grant, ev, ei);
        end else begin
          $display("ok   %s vec %0d: grant=%b vld=%b idx=%0d",
                   e.tag, vectors, grant, grant_vld, grant_idx);
        end
      end
    end
  end

  initial begin
    logic [W-1:0] rr_seq [5];
    logic [W-1:0] hl_seq [10];
    rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    hl_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010,
               4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};

    // Reset held with all requests active: no grant.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0000, "reset");

    // Round-robin rotation starting from pointer bit 0.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 4'b1111, 4'b0000, rr_seq[i], "rr_rot");

    // Fixed priority, then all requests dropped.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'b1010, 4'b0000, 4'b0010, "fixed");
    step(1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, "fixed_idle");

    // Hold limit: 4 cycles held, 1 cycle for the other channel, repeat.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 4'b0011, 4'b0001, hl_seq[i], "hold_lim");

    // Granted channel drops req; lock on a non-granted channel is ignored.
    step(1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0001, "drop_req");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 4'b0011, 4'b0010, 4'b0001, "lock_other");

    // Sole holder keeps the grant with no gap across forced releases.
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 4'b0100, 4'b0100, 4'b0100, "sole_hold");

    // Mode change does not break the active hold (3 more held cycles).
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'b0101, 4'b0100, 4'b0100, "mode_hold");
    step(1'b0, 1'b0, 4'b0101, 4'b0100, 4'b0001, "mode_rel");

    // Reset in the middle of a hold at count 2.
    step(1'b0, 1'b0, 4'b0001, 4'b0001, 4'b0001, "pre_rst");
    step(1'b0, 1'b0, 4'b0001, 4'b0001, 4'b0001, "pre_rst");
    step(1'b1, 1'b1, 4'b0110, 4'b0000, 4'b0000, "rst_hold");
    step(1'b0, 1'b1, 4'b0110, 4'b0000, 4'b0010, "post_rst");
    step(1'b0, 1'b1, 4'b0110, 4'b0000, 4'b0100, "post_rst");

    // Pointer returns to bit 0 on reset, then wraps over sparse requests.
    step(1'b1, 1'b1, 4'b1001, 4'b0000, 4'b0000, "rst_ptr");
    step(1'b0, 1'b1, 4'b1001, 4'b0000, 4'b0001, "ptr_zero");
    step(1'b0, 1'b1, 4'b1001, 4'b0000, 4'b1000, "rr_wrap");
    step(1'b0, 1'b1, 4'b1001, 4'b0000, 4'b0001, "rr_wrap");

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(posedge clk);
    #2;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uv_arb_rr.md
UV_ARB_RR -- requirements
Module: uv_arb_rr

Interface
REQ-001 Parameter WIDTH, default 4: number of requesters, range 2..32.
REQ-002 Parameter MAX_HOLD, default 16: maximum consecutive locked-grant cycles; 0 disables the limit.
REQ-003 Localparam IDX_W = max(1, clog2(WIDTH)); localparam CNT_W = max(1, clog2(MAX_HOLD+1)).
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 mode  input  1  0 = fixed priority (index 0 highest), 1 = round-robin.
REQ-007 req  input  WIDTH  per-channel request, level-sensitive.
REQ-008 lock  input  WIDTH  per-channel hold request; meaningful only for the currently granted channel.
REQ-009 grant  output  WIDTH  registered one-hot grant, or all-zero.
REQ-010 grant_vld  output  1  registered; equals OR of grant.
REQ-011 grant_idx  output  IDX_W  registered binary index of the granted channel; 0 when grant_vld=0.

Function
REQ-012 State: grant register, round-robin pointer ptr (one-hot WIDTH), hold counter cnt (CNT_W).
REQ-013 Latency: grant reflects the arbitration decision made on the previous cycle's req/lock/mode; req-to-grant is 1 cycle.
REQ-014 Hold condition: grant_vld & req[g] & lock[g], g = current grant index.
REQ-015 Forced release: hold condition & MAX_HOLD != 0 & cnt == MAX_HOLD-1.
REQ-016 Hold without forced release: grant, grant_idx and ptr unchanged; cnt <= cnt+1.
REQ-017 Otherwise re-arbitrate every cycle: new grant = winner(req_eff); cnt <= 0.
REQ-018 req_eff = req with bit g cleared on forced release; if that clears all bits, req_eff = req, so the current holder re-wins and cnt restarts at 0.
REQ-019 Fixed mode winner: lowest-index set bit of req_eff.
REQ-020 Round-robin winner: first set bit of req_eff at or above ptr position, wrapping from WIDTH-1 to 0.
REQ-021 req_eff == 0: grant <= 0, grant_vld <= 0, grant_idx <= 0, ptr unchanged.
REQ-022 ptr updates only when a new winner w is loaded in round-robin mode: ptr <= one-hot of (w+1) mod WIDTH; in fixed mode, ptr is held.
REQ-023 Mode change takes effect on the next arbitration decision; it does not break an active hold.
REQ-024 Granted channel dropping req ends the grant immediately; the next cycle shows the re-arbitrated winner, or zero.
REQ-025 Lock asserted on a non-granted channel has no effect.
REQ-026 grant is always one-hot or zero; grant_idx is always consistent with grant in the same cycle.

Reset
REQ-027 While rst=1 at a rising edge: grant=0, grant_vld=0, grant_idx=0, ptr=one-hot bit 0, cnt=0.
REQ-028 Reset mid-hold aborts the grant at that edge; the first arbitration after release of rst uses ptr=bit 0.
REQ-029 Outputs are registered only; no combinational path from inputs to outputs.

Verification (WIDTH=4, MAX_HOLD=4 unless stated)
REQ-030 Reset: assert rst with req=1111 -> grant=0000, grant_vld=0, grant_idx=0 throughout; after release, first grant=0001.
REQ-031 Round-robin: mode=1, req=1111, lock=0 -> grant sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles.
REQ-032 Fixed priority: mode=0, req=1010, lock=0 -> grant=0010 and grant_idx=1 every cycle; then req=0000 -> grant=0000 and grant_vld=0 the next cycle.
REQ-033 Hold limit: mode=0, req=0011, lock=0001 -> grant=0001 for 4 cycles, 0010 for 1 cycle, then 0001 for 4 cycles, repeating.
REQ-034 Sole holder: req=0100, lock=0100, either mode -> grant=0100 continuously; cnt wraps 0..3 and no grant gap occurs.
REQ-035 Reset during hold: holding 0001 with cnt=2, then rst=1 for one cycle with mode=1 and req=0110 -> grant=0000 during reset, then 0010.
